// File: rtl/leb128_stream_i64_if.sv
// Byte-in / value-out stream bundle for the signed-64 LEB128 decoder.
// The master side produces bytes and consumes decoded beats.
interface leb128_stream_i64_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] m_data;
    logic [3:0]  m_len;
    logic        m_err;
    logic        m_valid;
    logic        m_ready;

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_len, m_err, m_valid
    );

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_len, m_err, m_valid
    );
endinterface

// File: rtl/leb128_stream_i64.sv
// Streaming signed-64 LEB128 decoder: collects up to 10 bytes,
// emits one decoded value per beat, drains overlong encodings.
module unpack_i64 (
    input  logic [79:0] i_win,
    output logic [63:0] o_data,
    output logic [3:0]  o_len
);
    logic [63:0] w_acc;
    logic [63:0] w_ext;
    logic [6:0]  w_grp;
    logic        w_done;
    logic        w_sign;

    always_comb begin
        w_acc  = '0;
        w_ext  = '0;
        w_grp  = '0;
        w_done = 1'b0;
        w_sign = 1'b0;
        o_len  = '0;
        for (int k = 0; k < 10; k++) begin
            w_grp = i_win[72-8*k +: 7];
            if (!w_done) begin
                // groups past bit 63 fall off the 64-bit shift
                w_acc  = w_acc | (64'(w_grp) << (7*k));
                w_sign = w_grp[6];
                o_len  = 4'(k + 1);
                w_done = ~i_win[79-8*k];
            end
        end
        if (!w_done)
            o_len = '0;
        if (w_done && w_sign && o_len < 4'd10)
            w_ext = {64{1'b1}} << (7*o_len);
        o_data = w_acc | w_ext;
    end
endmodule

module leb128_stream_i64 (
    input  logic                 clk,
    input  logic                 rst_n,
    leb128_stream_i64_if.slave   bus
);
    typedef enum logic [1:0] {COLLECT, HOLD, DRAIN} state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [9:0][7:0] r_buf;
    logic            r_drain;
    logic            r_s_ready;
    logic            r_m_valid;
    logic [63:0]     r_m_data;
    logic [3:0]      r_m_len;
    logic            r_m_err;

    logic [79:0]     w_win;
    logic [63:0]     w_dec_data;
    logic [3:0]      w_dec_len;
    logic            w_take;

    // the incoming byte sits at position cnt so a terminator decodes this edge
    always_comb begin
        w_win = '0;
        for (int k = 0; k < 10; k++) begin
            if (4'(k) < r_cnt)
                w_win[79-8*k -: 8] = r_buf[k];
            else if (4'(k) == r_cnt)
                w_win[79-8*k -: 8] = bus.s_data;
        end
    end

    unpack_i64 u_dec (
        .i_win  (w_win),
        .o_data (w_dec_data),
        .o_len  (w_dec_len)
    );

    assign w_take = bus.s_valid & r_s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_buf     <= '0;
            r_drain   <= 1'b0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_len   <= '0;
            r_m_err   <= 1'b0;
        end else begin
            unique case (r_state)
                COLLECT: begin
                    if (w_take) begin
                        r_buf[r_cnt] <= bus.s_data;
                        if (!bus.s_data[7]) begin
                            r_m_data  <= w_dec_data;
                            r_m_len   <= w_dec_len;
                            r_m_err   <= 1'b0;
                            r_cnt     <= '0;
                            r_state   <= HOLD;
                            r_s_ready <= 1'b0;
                            r_m_valid <= 1'b1;
                        end else if (r_cnt == 4'd9) begin
                            r_m_data  <= '0;
                            r_m_len   <= '0;
                            r_m_err   <= 1'b1;
                            r_drain   <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= HOLD;
                            r_s_ready <= 1'b0;
                            r_m_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_drain   <= 1'b0;
                        r_state   <= r_drain ? DRAIN : COLLECT;
                    end
                end
                DRAIN: begin
                    // the tail of an overlong value never becomes a beat
                    if (w_take && !bus.s_data[7])
                        r_state <= COLLECT;
                end
                default: begin
                    r_state   <= COLLECT;
                    r_s_ready <= 1'b1;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_len   = r_m_len;
    assign bus.m_err   = r_m_err;
endmodule
